// File: rtl/nonce_uplink_tx_pkg.sv
// Shared constants for the cluster nonce link: serialiser state encoding and baud divider helper.
package nonce_uplink_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned BITS_PER_BYTE  = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Truncating divide; the receiver side uses the same value for its sampling.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous circular-buffer FIFO with wrap-bit pointers; a push when full is accepted only
// if a pop happens on the same edge, otherwise it is dropped.
module nonce_fifo #(
  parameter int unsigned W          = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_q, wr_d;
  logic [DEPTH_LOG2:0] rd_q, rd_d;
  logic                do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                   (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
  assign level_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[DEPTH_LOG2-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full, the write slot is the head slot; the head is read out before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= din_i;
  end

endmodule

// File: rtl/nonce_uplink_tx.sv
// Miner uplink: queues golden nonces and sends each as four LSB-first 8N1 bytes on TxD.
// TxD, busy and overflow come straight from flops.
module nonce_uplink_tx
  import nonce_uplink_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         nonce,
  input  logic                new_nonce,
  output logic                TxD,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);

  tx_state_e           state_q;
  logic                txd_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bit_q;
  logic [1:0]          byte_q;
  logic [31:0]         shreg_q;
  logic                busy_q, busy_d;
  logic                ovf_q;

  logic [31:0]         fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level, level_nxt;
  logic                pop, push_ok, drop, tick, frame_end, idle_next;

  nonce_fifo #(
    .W          (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (new_nonce),
    .din_i   (nonce),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign push_ok   = new_nonce && (!fifo_full || pop);
  assign drop      = new_nonce && fifo_full && !pop;
  assign tick      = (cnt_q == CW'(DIV - 1));
  assign frame_end = (state_q == ST_STOP) && tick && (byte_q == 2'(BYTES_PER_WORD - 1));
  assign idle_next = ((state_q == ST_IDLE) && fifo_empty) || frame_end;

  // busy looks one edge ahead so it rises with the push and falls on the edge that idles the line.
  always_comb begin
    level_nxt = fifo_level + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop};
    busy_d    = !idle_next || (level_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (drop) ovf_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          cnt_q <= '0;
          if (!fifo_empty) begin
            shreg_q <= fifo_dout;
            byte_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= shreg_q[0];
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // The word shifts right one bit per data bit, so bit 0 always holds the next bit to send.
        ST_DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (byte_q != 2'(BYTES_PER_WORD - 1)) begin
              byte_q  <= byte_q + 2'd1;
              txd_q   <= 1'b0;
              state_q <= ST_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TxD      = txd_q;
  assign busy     = busy_q;
  assign level    = fifo_level;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nonce_uplink_tx.sv
// Directed bench: DIV=8 instance for queueing/overflow/reset cases, default-rate instance for DIV=868.
module tb_nonce_uplink_tx;

  logic        clk = 1'b0;
  logic        rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic [31:0] nonce_a = '0, nonce_b = '0;
  logic        nn_a = 1'b0, nn_b = 1'b0;
  logic        tx_a, tx_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [2:0]  level_a, level_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nonce_uplink_tx #(.CLK_HZ(8), .BAUD(1), .DEPTH_LOG2(2)) dut_a (
    .clk(clk), .reset(rst_a_n), .nonce(nonce_a), .new_nonce(nn_a),
    .TxD(tx_a), .busy(busy_a), .level(level_a), .overflow(ovf_a)
  );

  nonce_uplink_tx #(.CLK_HZ(100_000_000), .BAUD(115_200), .DEPTH_LOG2(2)) dut_b (
    .clk(clk), .reset(rst_b_n), .nonce(nonce_b), .new_nonce(nn_b),
    .TxD(tx_b), .busy(busy_b), .level(level_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a_n = 1'b0;
    step();
    step();
    rst_a_n = 1'b1;
    step();
  endtask

  // Walks one word frame from cycle 'skip' (cycle 0 = first start-bit cycle), comparing every
  // cycle against an 8N1 LSB-first reference and decoding each data bit at its midpoint.
  task automatic frame_chk(input logic [31:0] w, input int div, input int skip, input bit use_b,
                           output int errs, output logic [31:0] dec, output logic busy_end);
    logic tx, expb;
    int fb, by, pos;
    errs = 0;
    dec = '0;
    busy_end = 1'b0;
    for (int t = skip; t < 40 * div; t++) begin
      tx  = use_b ? tx_b : tx_a;
      fb  = t / div;
      by  = fb / 10;
      pos = fb % 10;
      if (pos == 0)      expb = 1'b0;
      else if (pos == 9) expb = 1'b1;
      else               expb = w[by * 8 + pos - 1];
      if (tx !== expb) errs++;
      if ((t % div) == (div / 2) && pos >= 1 && pos <= 8) dec[by * 8 + pos - 1] = tx;
      if (t == 40 * div - 1) busy_end = use_b ? busy_b : busy_a;
      step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    logic [31:0] dec;
    logic be;
    logic [31:0] w2 [6];
    logic [31:0] w3 [6];
    logic [2:0]  lvl2 [6];

    w2 = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00FF00FF, 32'h80000001, 32'h3C3C3C3C, 32'hFFFFFFFF};
    w3 = '{32'hCAFEF00D, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0BADF00D};
    lvl2 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    // Reset state
    step();
    step();
    chk("rst txd", 32'(tx_a), 32'd1);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst level", 32'(level_a), 32'd0);
    chk("rst ovf", 32'(ovf_a), 32'd0);
    chk("rst txd_b", 32'(tx_b), 32'd1);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step();

    // Single word
    nonce_a = 32'h12345678; nn_a = 1'b1; step(); nn_a = 1'b0;
    chk("t1 busy rise", 32'(busy_a), 32'd1);
    chk("t1 level push", 32'(level_a), 32'd1);
    chk("t1 txd E0", 32'(tx_a), 32'd1);
    step();
    chk("t1 txd E1", 32'(tx_a), 32'd0);
    chk("t1 level pop", 32'(level_a), 32'd0);
    frame_chk(32'h12345678, 8, 0, 1'b0, errs, dec, be);
    chk("t1 line", 32'(errs), 32'd0);
    chk("t1 b0", 32'(dec[7:0]), 32'h78);
    chk("t1 b1", 32'(dec[15:8]), 32'h56);
    chk("t1 b2", 32'(dec[23:16]), 32'h34);
    chk("t1 b3", 32'(dec[31:24]), 32'h12);
    chk("t1 busy last", 32'(be), 32'd1);
    chk("t1 busy fall", 32'(busy_a), 32'd0);
    chk("t1 txd idle", 32'(tx_a), 32'd1);
    chk("t1 ovf", 32'(ovf_a), 32'd0);

    // Six back-to-back pushes: five sent, the sixth dropped
    reset_a();
    for (int i = 0; i < 6; i++) begin
      nonce_a = w2[i]; nn_a = 1'b1; step();
      chk("t2 level", 32'(level_a), 32'(lvl2[i]));
      chk("t2 ovf", 32'(ovf_a), (i == 5) ? 32'd1 : 32'd0);
    end
    nn_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame_chk(w2[i], 8, (i == 0) ? 4 : 0, 1'b0, errs, dec, be);
      chk("t2 line", 32'(errs), 32'd0);
      chk("t2 word", dec, w2[i]);
      if (i < 4) begin
        chk("t2 gap txd", 32'(tx_a), 32'd1);
        chk("t2 gap busy", 32'(busy_a), 32'd1);
        step();
      end
    end
    chk("t2 end busy", 32'(busy_a), 32'd0);
    chk("t2 end level", 32'(level_a), 32'd0);
    chk("t2 end ovf", 32'(ovf_a), 32'd1);
    step();
    chk("t2 end txd", 32'(tx_a), 32'd1);

    // Push coinciding with a pop while full
    reset_a();
    for (int i = 0; i < 5; i++) begin
      nonce_a = w3[i]; nn_a = 1'b1; step();
      chk("t3 level", 32'(level_a), 32'(lvl2[i]));
    end
    nn_a = 1'b0;
    frame_chk(w3[0], 8, 3, 1'b0, errs, dec, be);
    chk("t3 line0", 32'(errs), 32'd0);
    chk("t3 full", 32'(level_a), 32'd4);
    nonce_a = w3[5]; nn_a = 1'b1; step(); nn_a = 1'b0;
    chk("t3 level same", 32'(level_a), 32'd4);
    chk("t3 ovf", 32'(ovf_a), 32'd0);
    chk("t3 txd start", 32'(tx_a), 32'd0);
    for (int i = 1; i < 6; i++) begin
      frame_chk(w3[i], 8, 0, 1'b0, errs, dec, be);
      chk("t3 line", 32'(errs), 32'd0);
      chk("t3 word", dec, w3[i]);
      if (i < 5) step();
    end
    chk("t3 end busy", 32'(busy_a), 32'd0);
    chk("t3 end ovf", 32'(ovf_a), 32'd0);

    // Reset mid-frame with two words queued
    reset_a();
    nonce_a = 32'h5A5A0000; nn_a = 1'b1; step(); nn_a = 1'b0;
    step();
    nonce_a = 32'h01020304; nn_a = 1'b1; step();
    nonce_a = 32'h05060708; step(); nn_a = 1'b0;
    chk("t4 queued", 32'(level_a), 32'd2);
    for (int i = 0; i < 98; i++) step();
    chk("t4 txd pre", 32'(tx_a), 32'd0);
    rst_a_n = 1'b0;
    #1;
    chk("t4 txd async", 32'(tx_a), 32'd1);
    chk("t4 level", 32'(level_a), 32'd0);
    chk("t4 busy", 32'(busy_a), 32'd0);
    step();
    rst_a_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) errs++;
    end
    chk("t4 stays idle", 32'(errs), 32'd0);
    nonce_a = 32'h0000_00FF; nn_a = 1'b1; step(); nn_a = 1'b0;
    step();
    chk("t4 new start", 32'(tx_a), 32'd0);

    // Full-rate divider
    nonce_b = 32'hDEADBEEF; nn_b = 1'b1; step(); nn_b = 1'b0;
    step();
    chk("t5 txd E1", 32'(tx_b), 32'd0);
    frame_chk(32'hDEADBEEF, 868, 0, 1'b1, errs, dec, be);
    chk("t5 line", 32'(errs), 32'd0);
    chk("t5 b0", 32'(dec[7:0]), 32'hEF);
    chk("t5 b1", 32'(dec[15:8]), 32'hBE);
    chk("t5 b2", 32'(dec[23:16]), 32'hAD);
    chk("t5 b3", 32'(dec[31:24]), 32'hDE);
    chk("t5 busy last", 32'(be), 32'd1);
    chk("t5 busy fall", 32'(busy_b), 32'd0);
    chk("t5 ovf", 32'(ovf_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonce_uplink_tx.md
# nonce_uplink_tx

Miner-side uplink transmitter: accepts 32-bit golden nonces from the local hasher, queues them in a small FIFO, and serialises each one onto a single async line as four 8N1 bytes. It sits at the slave end of the cluster nonce link: its `TxD` feeds a hub's slave receiver, either directly on the same FPGA or through an external port. It replaces the unbuffered word transmitter in miners, so nonces found back-to-back are no longer lost while a frame is in flight.

## Interface
- `CLK_HZ`, 100_000_000 — frequency of `clk` in Hz.
- `BAUD`, 115_200 — line rate; `DIV = CLK_HZ / BAUD` (integer, truncated, must be ≥ 2).
- `DEPTH_LOG2`, 2 — FIFO holds `2**DEPTH_LOG2` nonces.

- `clk`  in  1  hash clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears FIFO, FSM, flags.
- `nonce`  in  32  golden nonce to queue.
- `new_nonce`  in  1  single-cycle strobe; `nonce` is sampled when high.
- `TxD`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a nonce is dropped.

## Operation
- Reset values: `TxD`=1, `busy`=0, `level`=0, `overflow`=0, FSM=IDLE.
- FIFO: circular buffer with write/read pointers of DEPTH_LOG2+1 bits, so full and empty are distinguishable.
  - Push on `new_nonce`.
  - Pop when the FSM loads a word.
  - Push and pop on the same edge are both performed and `level` is unchanged.
  - Push when full with no pop on that edge: the nonce is dropped, FIFO contents are unchanged, and `overflow` is set. `overflow` is cleared only by reset.
- FSM states:
  - IDLE: `TxD`=1. If the FIFO is non-empty, load the head word into the shift register, pop it, set byte index 0, and go to START.
  - START: `TxD`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `TxD` = current byte bit[i], LSB first, DIV cycles per bit. After bit 7 go to STOP.
  - STOP: `TxD`=1 for DIV cycles. If byte index < 3, increment it and go to START. Otherwise go to IDLE.
- Byte order: least-significant byte first. Word 0x12345678 is sent as 0x78, 0x56, 0x34, 0x12.
- Bit timer: counts 0..DIV-1 and is reloaded on every state or bit change. There is no fractional-baud correction.
- Reset asserted mid-frame: `TxD` goes high immediately and asynchronously. The partial frame is abandoned and queued nonces are discarded.

## Timing
- `new_nonce` sampled at edge E0 with the FSM in IDLE and the FIFO empty: the word is written at E0 and loaded at E1. `TxD` falls after E1 (registered output).
- A word frame is 4 × 10 × DIV cycles. Consecutive queued words follow with exactly one extra IDLE cycle between the last stop bit and the next start bit.
- `busy` is registered: it rises at E0 together with the push and falls on the edge that enters IDLE with the FIFO empty.
- `level` reflects the edge just taken. `overflow` is set on the dropping edge.
- `TxD` is glitch-free: driven only from a flop, with no combinational path from the inputs.

## Structure
- Shared package holds the FSM state encoding (IDLE, START, DATA, STOP) and `DIV` computation helper; the hub's slave receiver uses the same constants for its sampling.
- One sub-module: `nonce_fifo` (parameterised synchronous FIFO, async active-low reset, push/pop/full/empty/level). The serialiser FSM stays in the top.

## Test plan
Use `CLK_HZ`=8, `BAUD`=1 (DIV=8) and `DEPTH_LOG2`=2 unless stated.
- Single push of 0x12345678 at E0 -> `TxD` low from E1 and bytes 0x78, 0x56, 0x34, 0x12 (8N1, LSB first) over 320 cycles. `busy` falls at E1+320, `overflow`=0.
- Six pushes on consecutive edges E0..E5 -> words 0..4 transmitted in order, word 5 dropped. `overflow`=1 from E5, `level` peaks at 4, and 1600 cycles of frames plus 4 IDLE gaps.
- Push on the same edge as a pop with the FIFO full (`level`=4) -> both occur, `level` stays 4, `overflow` stays 0.
- Reset asserted 100 cycles into a frame with 2 words queued -> `TxD`=1 immediately, `level`=0, `busy`=0. After release the line stays idle until a new push arrives.
- `DIV`=868 (100 MHz / 115200), push 0xDEADBEEF -> each bit lasts exactly 868 cycles and a reference UART model decodes 0xEF, 0xBE, 0xAD, 0xDE.
